// File: rtl/loop_ctrl.sv
// Loop-bracket controller: resolves '[' / ']' PC redirection with a return-address
// stack and squashes instructions while skipping forward over a zero-cell loop.
module loop_ctrl #(
    parameter int PW    = 8,
    parameter int DEPTH = 16,
    parameter int NW    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    input  logic                       is_open,
    input  logic                       is_close,
    input  logic                       cell_zero,
    input  logic [PW-1:0]              pc,
    output logic                       pc_load,
    output logic [PW-1:0]              pc_target,
    output logic                       bubble,
    output logic                       skipping,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [1:0]                 dbg_state,
    output logic [NW-1:0]              dbg_nest
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    localparam logic [1:0] CODE_OVF = 2'b01;
    localparam logic [1:0] CODE_UNF = 2'b10;
    localparam logic [1:0] CODE_DEC = 2'b11;

    logic [1:0]    state, state_n;
    logic [NW-1:0] nest, nest_n;
    logic [DW-1:0] sp, sp_n;
    logic [1:0]    code, code_n;
    logic          push;
    logic [PW-1:0] stack [DEPTH];
    logic [AW-1:0] top_idx;

    // sp counts entries; the low bits wrap so a full stack still indexes its top.
    assign top_idx   = sp[AW-1:0] - AW'(1);
    assign pc_target = (sp != '0) ? stack[top_idx] : '0;

    always_comb begin
        state_n = state;
        nest_n  = nest;
        sp_n    = sp;
        code_n  = code;
        push    = 1'b0;
        pc_load = 1'b0;
        bubble  = (state != ST_RUN);
        case (state)
            ST_RUN: begin
                if (instr_valid) begin
                    if (is_open && is_close) begin
                        state_n = ST_ERR;
                        code_n  = CODE_DEC;
                    end else if (is_close) begin
                        if (sp == '0) begin
                            state_n = ST_ERR;
                            code_n  = CODE_UNF;
                        end else if (cell_zero) begin
                            sp_n = sp - DW'(1);
                        end else begin
                            pc_load = 1'b1;
                        end
                    end else if (is_open) begin
                        if (cell_zero) begin
                            nest_n  = NW'(1);
                            state_n = ST_SKIP;
                        end else if (sp == DW'(DEPTH)) begin
                            state_n = ST_ERR;
                            code_n  = CODE_OVF;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + DW'(1);
                        end
                    end
                end
            end
            ST_SKIP: begin
                // Bracket matching only; cell value and stack are irrelevant here.
                if (instr_valid) begin
                    if (is_open && is_close) begin
                        state_n = ST_ERR;
                        code_n  = CODE_DEC;
                    end else if (is_open) begin
                        if (&nest) begin
                            state_n = ST_ERR;
                            code_n  = CODE_OVF;
                        end else begin
                            nest_n = nest + NW'(1);
                        end
                    end else if (is_close) begin
                        nest_n = nest - NW'(1);
                        if (nest == NW'(1)) state_n = ST_RUN;
                    end
                end
            end
            ST_ERR: begin
            end
            default: begin
                state_n = ST_ERR;
                code_n  = CODE_DEC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            nest  <= '0;
            sp    <= '0;
            code  <= 2'b00;
        end else begin
            state <= state_n;
            nest  <= nest_n;
            sp    <= sp_n;
            code  <= code_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack[sp[AW-1:0]] <= pc + PW'(1);
    end

    assign skipping  = (state == ST_SKIP);
    assign err       = (state == ST_ERR);
    assign err_code  = code;
    assign depth     = sp;
    assign dbg_state = state;
    assign dbg_nest  = nest;
endmodule

// File: tb/tb_loop_ctrl.sv
// Directed bench for loop_ctrl: loops, nested skip, stack faults, bubbles and async reset.
module tb_loop_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic       is_open = 1'b0;
    logic       is_close = 1'b0;
    logic       cell_zero = 1'b0;
    logic [7:0] pc = '0;
    logic       pc_load;
    logic [7:0] pc_target;
    logic       bubble;
    logic       skipping;
    logic [4:0] depth;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] dbg_state;
    logic [7:0] dbg_nest;

    int checks = 0;
    int errors = 0;

    loop_ctrl #(.PW(8), .DEPTH(16), .NW(8)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .is_open(is_open),
        .is_close(is_close), .cell_zero(cell_zero), .pc(pc), .pc_load(pc_load),
        .pc_target(pc_target), .bubble(bubble), .skipping(skipping), .depth(depth),
        .err(err), .err_code(err_code), .dbg_state(dbg_state), .dbg_nest(dbg_nest)
    );

    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input logic v, input logic o, input logic c, input logic z,
                         input logic [7:0] p);
        @(negedge clk);
        instr_valid = v;
        is_open     = o;
        is_close    = c;
        cell_zero   = z;
        pc          = p;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, $urandom_range(0, 1), 8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        instr_valid = 1'b0; is_open = 1'b0; is_close = 1'b0; cell_zero = 1'b0; pc = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load got=%0d exp=0", pc_load); end
        checks++; if (pc_target !== 8'd0) begin errors++; $display("FAIL reset_pc_target got=%0d exp=0", pc_target); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got=%0d exp=0", bubble); end
        checks++; if (skipping !== 1'b0) begin errors++; $display("FAIL reset_skipping got=%0d exp=0", skipping); end
        checks++; if (depth !== 5'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL reset_err got=%0d/%0d exp=0/0", err, err_code); end
    endtask

    task automatic test_simple_loop();
        do_reset();
        apply(1, 1, 0, 0, 8'd4);
        checks++; if (pc_load !== 1'b0 || bubble !== 1'b0) begin errors++; $display("FAIL loop_open got=%0d/%0d exp=0/0", pc_load, bubble); end
        for (int k = 0; k < 2; k++) begin
            apply(1, 0, 1, 0, 8'd7);
            checks++; if (depth !== 5'd1) begin errors++; $display("FAIL loop_depth%0d got=%0d exp=1", k, depth); end
            checks++; if (pc_load !== 1'b1 || pc_target !== 8'd5) begin errors++; $display("FAIL loop_jump%0d got=%0d/%0d exp=1/5", k, pc_load, pc_target); end
        end
        apply(1, 0, 1, 1, 8'd7);
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL loop_exit got=%0d exp=0", pc_load); end
        idle();
        checks++; if (depth !== 5'd0 || skipping !== 1'b0) begin errors++; $display("FAIL loop_after got=%0d/%0d exp=0/0", depth, skipping); end
    endtask

    task automatic test_nested_skip();
        // '[' '[' ']' '+' ']' ']' : open/close per step and nest seen before each step.
        logic [5:0] opn;
        logic [5:0] cls;
        logic [7:0] nest_before [6];
        opn = 6'b000011;
        cls = 6'b110100;
        nest_before = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd2, 8'd1};
        do_reset();
        apply(1, 1, 0, 1, 8'd2);
        checks++; if (bubble !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("FAIL skip_enter got=%0d/%0d exp=0/0", bubble, pc_load); end
        for (int i = 0; i < 6; i++) begin
            apply(1, opn[i], cls[i], $urandom_range(0, 1), 8'(3 + i));
            checks++; if (bubble !== 1'b1 || pc_load !== 1'b0 || skipping !== 1'b1) begin errors++; $display("FAIL skip_step%0d got=%0d/%0d/%0d exp=1/0/1", i, bubble, pc_load, skipping); end
            checks++; if (dbg_nest !== nest_before[i] || depth !== 5'd0) begin errors++; $display("FAIL skip_nest%0d got=%0d/%0d exp=%0d/0", i, dbg_nest, depth, nest_before[i]); end
        end
        idle();
        checks++; if (skipping !== 1'b0 || bubble !== 1'b0 || dbg_nest !== 8'd0 || depth !== 5'd0) begin errors++; $display("FAIL skip_exit got=%0d/%0d/%0d/%0d exp=0/0/0/0", skipping, bubble, dbg_nest, depth); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        apply(1, 1, 0, 0, 8'd30);
        apply(1, 1, 0, 0, 8'd32);
        apply(1, 0, 1, 0, 8'd34);
        checks++; if (pc_load !== 1'b1 || pc_target !== 8'd33) begin errors++; $display("FAIL b2b_new_top got=%0d/%0d exp=1/33", pc_load, pc_target); end
        apply(1, 0, 1, 1, 8'd35);
        apply(1, 0, 1, 0, 8'd36);
        checks++; if (pc_load !== 1'b1 || pc_target !== 8'd31 || depth !== 5'd1) begin errors++; $display("FAIL b2b_after_pop got=%0d/%0d/%0d exp=1/31/1", pc_load, pc_target, depth); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) apply(1, 1, 0, 0, 8'(i));
        idle();
        checks++; if (depth !== 5'd16 || err !== 1'b0 || pc_target !== 8'd16) begin errors++; $display("FAIL ovf_full got=%0d/%0d/%0d exp=16/0/16", depth, err, pc_target); end
        apply(1, 1, 0, 0, 8'd100);
        idle();
        checks++; if (err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL ovf_err got=%0d/%0d exp=1/1", err, err_code); end
        checks++; if (bubble !== 1'b1 || depth !== 5'd16 || pc_target !== 8'd16) begin errors++; $display("FAIL ovf_hold got=%0d/%0d/%0d exp=1/16/16", bubble, depth, pc_target); end
        apply(1, 0, 1, 0, 8'd101);
        checks++; if (pc_load !== 1'b0 || bubble !== 1'b1) begin errors++; $display("FAIL ovf_no_jump got=%0d/%0d exp=0/1", pc_load, bubble); end
    endtask

    task automatic test_underflow();
        do_reset();
        apply(1, 0, 1, 1, 8'd3);
        idle();
        checks++; if (err !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL unf_err got=%0d/%0d exp=1/2", err, err_code); end
        apply(1, 1, 0, 0, 8'd5);
        idle();
        checks++; if (depth !== 5'd0 || err_code !== 2'b10 || bubble !== 1'b1) begin errors++; $display("FAIL unf_ignore got=%0d/%0d/%0d exp=0/2/1", depth, err_code, bubble); end
    endtask

    task automatic test_bubbles_reset();
        do_reset();
        apply(1, 1, 0, 0, 8'd10);
        apply(0, 0, 1, 0, 8'd20);
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL bub_no_jump got=%0d exp=0", pc_load); end
        apply(0, 1, 0, 0, 8'd21);
        checks++; if (depth !== 5'd1) begin errors++; $display("FAIL bub_depth got=%0d exp=1", depth); end
        apply(1, 1, 0, 1, 8'd12);
        apply(1, 1, 0, 0, 8'd13);
        apply(0, 0, 1, 0, 8'd14);
        apply(1, 1, 0, 1, 8'd15);
        apply(0, 0, 1, 1, 8'd16);
        checks++; if (dbg_nest !== 8'd3 || skipping !== 1'b1 || bubble !== 1'b1 || depth !== 5'd1) begin errors++; $display("FAIL bub_skip got=%0d/%0d/%0d/%0d exp=3/1/1/1", dbg_nest, skipping, bubble, depth); end
        reset = 1'b0;
        #1;
        checks++; if (skipping !== 1'b0 || depth !== 5'd0 || bubble !== 1'b0 || pc_target !== 8'd0 || pc_load !== 1'b0) begin errors++; $display("FAIL async_reset got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0", skipping, depth, bubble, pc_target, pc_load); end
        checks++; if (err !== 1'b0 || err_code !== 2'b00 || dbg_nest !== 8'd0) begin errors++; $display("FAIL async_reset_err got=%0d/%0d/%0d exp=0/0/0", err, err_code, dbg_nest); end
        @(negedge clk);
        reset = 1'b1;
        apply(1, 1, 0, 0, 8'd40);
        apply(1, 0, 1, 0, 8'd45);
        checks++; if (pc_load !== 1'b1 || pc_target !== 8'd41 || depth !== 5'd1) begin errors++; $display("FAIL post_reset_run got=%0d/%0d/%0d exp=1/41/1", pc_load, pc_target, depth); end
    endtask

    task automatic test_decode_fault();
        do_reset();
        apply(1, 1, 1, 0, 8'd8);
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL dec_no_jump got=%0d exp=0", pc_load); end
        idle();
        checks++; if (err !== 1'b1 || err_code !== 2'b11) begin errors++; $display("FAIL dec_err got=%0d/%0d exp=1/3", err, err_code); end
        apply(1, 0, 1, 0, 8'd9);
        apply(1, 1, 0, 0, 8'd10);
        idle();
        checks++; if (err !== 1'b1 || err_code !== 2'b11 || depth !== 5'd0) begin errors++; $display("FAIL dec_sticky got=%0d/%0d/%0d exp=1/3/0", err, err_code, depth); end
    endtask

    initial begin
        test_reset();
        test_simple_loop();
        test_nested_skip();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_bubbles_reset();
        test_decode_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
